// File: rtl/addsub_pipe.sv
// Pipelined add/subtract with unsigned/signed modes, optional saturation and
// a valid/ready handshake on both sides.
module addsub_pipe #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2,
    parameter int SAT_EN = 0
) (
    input  logic             sclk,
    input  logic             srst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op_sub,
    input  logic             op_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   result,
    output logic             ovf,
    output logic [15:0]      op_count
);

    localparam int RW = WIDTH + 1;
    localparam logic [RW-1:0] U_MAX = {1'b0, {WIDTH{1'b1}}};
    localparam logic [RW-1:0] S_MAX = {2'b00, {(WIDTH-1){1'b1}}};
    localparam logic [RW-1:0] S_MIN = {2'b11, {(WIDTH-1){1'b0}}};

    logic [RW-1:0] a_ext;
    logic [RW-1:0] b_ext;
    logic [RW-1:0] sum_c;
    logic [RW-1:0] res_c;
    logic          ovf_c;

    // Result is fully computed at acceptance, so the mode bits never need
    // to travel down the pipe.
    always_comb begin
        a_ext = op_signed ? {a[WIDTH-1], a} : {1'b0, a};
        b_ext = op_signed ? {b[WIDTH-1], b} : {1'b0, b};
        sum_c = op_sub ? (a_ext - b_ext) : (a_ext + b_ext);
        ovf_c = op_signed ? (sum_c[WIDTH] ^ sum_c[WIDTH-1]) : sum_c[WIDTH];
        res_c = sum_c;
        if ((SAT_EN != 0) && ovf_c) begin
            if (op_signed) begin
                res_c = sum_c[WIDTH] ? S_MIN : S_MAX;
            end else begin
                res_c = op_sub ? '0 : U_MAX;
            end
        end
    end

    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] valid_d;
    logic [STAGES-1:0] ovf_q;
    logic [STAGES-1:0] ovf_d;
    logic [RW-1:0]     res_q [STAGES];
    logic [RW-1:0]     res_d [STAGES];
    logic [STAGES-1:0] ld;
    logic [15:0]       op_count_q;
    logic [15:0]       op_count_d;

    // A stage may load when empty or when its successor is moving this cycle.
    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_ld
            if (gi == STAGES - 1) begin : g_last
                assign ld[gi] = !valid_q[gi] || out_ready;
            end else begin : g_mid
                assign ld[gi] = !valid_q[gi] || ld[gi+1];
            end
        end
    endgenerate

    always_comb begin
        valid_d = valid_q;
        ovf_d   = ovf_q;
        res_d   = res_q;
        if (ld[0]) begin
            valid_d[0] = in_valid;
            ovf_d[0]   = ovf_c;
            res_d[0]   = res_c;
        end
        for (int k = 1; k < STAGES; k++) begin
            if (ld[k]) begin
                valid_d[k] = valid_q[k-1];
                ovf_d[k]   = ovf_q[k-1];
                res_d[k]   = res_q[k-1];
            end
        end
    end

    always_comb begin
        op_count_d = op_count_q;
        if (valid_q[STAGES-1] && out_ready) begin
            op_count_d = op_count_q + 16'd1;
        end
    end

    always_ff @(posedge sclk) begin
        if (srst) begin
            valid_q    <= '0;
            ovf_q      <= '0;
            op_count_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                res_q[k] <= '0;
            end
        end else begin
            valid_q    <= valid_d;
            ovf_q      <= ovf_d;
            res_q      <= res_d;
            op_count_q <= op_count_d;
        end
    end

    assign in_ready  = ld[0];
    assign out_valid = valid_q[STAGES-1];
    assign result    = res_q[STAGES-1];
    assign ovf       = ovf_q[STAGES-1];
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_addsub_pipe.sv
// Scoreboard bench for addsub_pipe: one non-saturating and one saturating
// instance share inputs; a monitor pops expected results on every transfer.
module tb_addsub_pipe;

    localparam int STAGES = 2;

    logic       sclk = 1'b0;
    logic       srst = 1'b1;
    logic       in_valid = 1'b0;
    logic [3:0] a = '0;
    logic [3:0] b = '0;
    logic       op_sub = 1'b0;
    logic       op_signed = 1'b0;
    logic       out_ready = 1'b1;

    logic        in_ready0, out_valid0, ovf0;
    logic [4:0]  result0;
    logic [15:0] op_count0;
    logic        in_ready1, out_valid1, ovf1;
    logic [4:0]  result1;
    logic [15:0] op_count1;

    always #5 sclk = ~sclk;

    addsub_pipe #(.WIDTH(4), .STAGES(STAGES), .SAT_EN(0)) dut0 (
        .sclk(sclk), .srst(srst), .in_valid(in_valid), .in_ready(in_ready0),
        .a(a), .b(b), .op_sub(op_sub), .op_signed(op_signed),
        .out_valid(out_valid0), .out_ready(out_ready), .result(result0),
        .ovf(ovf0), .op_count(op_count0)
    );

    addsub_pipe #(.WIDTH(4), .STAGES(STAGES), .SAT_EN(1)) dut1 (
        .sclk(sclk), .srst(srst), .in_valid(in_valid), .in_ready(in_ready1),
        .a(a), .b(b), .op_sub(op_sub), .op_signed(op_signed),
        .out_valid(out_valid1), .out_ready(out_ready), .result(result1),
        .ovf(ovf1), .op_count(op_count1)
    );

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       sub;
        logic       sgn;
        logic [4:0] r0;
        logic       o0;
        logic [4:0] r1;
        logic       o1;
    } vec_t;

    typedef struct {
        logic [4:0] r0;
        logic       o0;
        logic [4:0] r1;
        logic       o1;
        int         acc;
        bit         lat;
    } exp_t;

    vec_t  vecs [10];
    vec_t  v_inc;
    exp_t  exp_q [$];
    int    xfer_cyc [$];
    int    tests = 0;
    int    fails = 0;
    int    cyc = 0;
    bit    quiet = 1'b0;
    logic [15:0] xcnt = '0;
    bit          prev_stall = 1'b0;
    logic [4:0]  prev_res0, prev_res1;
    logic        prev_ovf0, prev_ovf1;

    always @(posedge sclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Monitor: compares every output transfer against the scoreboard head.
    always @(negedge sclk) begin
        if (srst) begin
            prev_stall = 1'b0;
            xcnt = '0;
        end else begin
            check("in_ready_match", {31'd0, in_ready1}, {31'd0, in_ready0});
            check("out_valid_match", {31'd0, out_valid1}, {31'd0, out_valid0});
            check("op_count0", {16'd0, op_count0}, {16'd0, xcnt});
            check("op_count1", {16'd0, op_count1}, {16'd0, xcnt});
            if (prev_stall) begin
                check("hold_valid", {31'd0, out_valid0}, 32'd1);
                check("hold_res0", {27'd0, result0}, {27'd0, prev_res0});
                check("hold_res1", {27'd0, result1}, {27'd0, prev_res1});
                check("hold_ovf0", {31'd0, ovf0}, {31'd0, prev_ovf0});
                check("hold_ovf1", {31'd0, ovf1}, {31'd0, prev_ovf1});
            end
            if (out_valid0 && out_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_output: got res=%b ovf=%b, expected no output", result0, ovf0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("result_nosat", {27'd0, result0}, {27'd0, e.r0});
                    check("ovf_nosat", {31'd0, ovf0}, {31'd0, e.o0});
                    check("result_sat", {27'd0, result1}, {27'd0, e.r1});
                    check("ovf_sat", {31'd0, ovf1}, {31'd0, e.o1});
                    if (e.lat) check("latency", cyc - e.acc, STAGES);
                    if (!quiet)
                        $display("[TB] xfer cyc=%0d res=%b ovf=%b sat_res=%b sat_ovf=%b",
                                 cyc, result0, ovf0, result1, ovf1);
                end
                xcnt = xcnt + 16'd1;
                xfer_cyc.push_back(cyc);
            end
            prev_stall = out_valid0 && !out_ready;
            prev_res0 = result0;
            prev_res1 = result1;
            prev_ovf0 = ovf0;
            prev_ovf1 = ovf1;
        end
    end

    task automatic send(input vec_t v, input bit lat);
        bit   accepted;
        exp_t e;
        a = v.a;
        b = v.b;
        op_sub = v.sub;
        op_signed = v.sgn;
        in_valid = 1'b1;
        accepted = 1'b0;
        for (int i = 0; i < 200 && !accepted; i++) begin
            @(negedge sclk);
            if (in_ready0) begin
                e = '{v.r0, v.o0, v.r1, v.o1, cyc, lat};
                exp_q.push_back(e);
                accepted = 1'b1;
            end
            @(posedge sclk);
            #1;
        end
        if (!accepted) fail_now("send_timeout");
        // Scramble inputs after acceptance; the accepted op must be unaffected.
        in_valid = 1'b0;
        op_sub = ~v.sub;
        op_signed = ~v.sgn;
        a = ~v.a;
        b = ~v.b;
    endtask

    task automatic drain();
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < 100) begin
            @(negedge sclk);
            i++;
        end
        if (exp_q.size() != 0) begin
            fail_now("drain_timeout");
            exp_q.delete();
        end
        @(posedge sclk);
        #1;
    endtask

    task automatic do_reset();
        srst = 1'b1;
        in_valid = 1'b0;
        exp_q.delete();
        @(posedge sclk);
        #1;
        srst = 1'b0;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{4'd3,  4'd5,  1'b1, 1'b0, 5'b11110, 1'b1, 5'b00000, 1'b1};
        vecs[1] = '{4'd7,  4'd1,  1'b0, 1'b1, 5'b01000, 1'b1, 5'b00111, 1'b1};
        vecs[2] = '{4'd8,  4'd1,  1'b1, 1'b1, 5'b10111, 1'b1, 5'b11000, 1'b1};
        vecs[3] = '{4'd15, 4'd1,  1'b0, 1'b0, 5'b10000, 1'b1, 5'b01111, 1'b1};
        vecs[4] = '{4'd5,  4'd6,  1'b0, 1'b0, 5'b01011, 1'b0, 5'b01011, 1'b0};
        vecs[5] = '{4'd13, 4'd12, 1'b0, 1'b1, 5'b11001, 1'b0, 5'b11001, 1'b0};
        vecs[6] = '{4'd8,  4'd8,  1'b0, 1'b1, 5'b10000, 1'b1, 5'b11000, 1'b1};
        vecs[7] = '{4'd9,  4'd4,  1'b1, 1'b0, 5'b00101, 1'b0, 5'b00101, 1'b0};
        vecs[8] = '{4'd7,  4'd15, 1'b1, 1'b1, 5'b01000, 1'b1, 5'b00111, 1'b1};
        vecs[9] = '{4'd0,  4'd15, 1'b1, 1'b0, 5'b10001, 1'b1, 5'b00000, 1'b1};
        v_inc   = '{4'd1,  4'd1,  1'b0, 1'b0, 5'b00010, 1'b0, 5'b00010, 1'b0};

        // Reset state
        srst = 1'b1;
        repeat (2) @(posedge sclk);
        #1;
        srst = 1'b0;
        @(negedge sclk);
        check("rst_out_valid", {31'd0, out_valid0}, 32'd0);
        check("rst_result", {27'd0, result0}, 32'd0);
        check("rst_ovf", {31'd0, ovf0}, 32'd0);
        check("rst_op_count", {16'd0, op_count0}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready0}, 32'd1);
        @(posedge sclk);
        #1;

        // Isolated directed ops with latency check
        for (int i = 0; i < 10; i++) begin
            send(vecs[i], 1'b1);
            drain();
        end

        // Back-to-back stream of 6
        do_reset();
        xfer_cyc.delete();
        for (int i = 0; i < 6; i++) send(vecs[i], 1'b1);
        drain();
        check("stream_count", xfer_cyc.size(), 6);
        for (int i = 1; i < xfer_cyc.size(); i++)
            check("stream_consecutive", xfer_cyc[i] - xfer_cyc[i-1], 1);
        @(negedge sclk);
        check("stream_op_count", {16'd0, op_count0}, 32'd6);
        @(posedge sclk);
        #1;

        // Backpressure: fill, hold, release
        out_ready = 1'b0;
        send(vecs[6], 1'b0);
        send(vecs[7], 1'b0);
        a = vecs[8].a;
        b = vecs[8].b;
        op_sub = vecs[8].sub;
        op_signed = vecs[8].sgn;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge sclk);
            check("stall_in_ready", {31'd0, in_ready0}, 32'd0);
            @(posedge sclk);
            #1;
        end
        out_ready = 1'b1;
        send(vecs[8], 1'b0);
        send(vecs[9], 1'b0);
        drain();

        // Reset with two ops in flight
        out_ready = 1'b0;
        send(vecs[0], 1'b0);
        send(vecs[1], 1'b0);
        do_reset();
        @(negedge sclk);
        check("flush_out_valid", {31'd0, out_valid0}, 32'd0);
        check("flush_op_count", {16'd0, op_count0}, 32'd0);
        check("flush_in_ready", {31'd0, in_ready0}, 32'd1);
        @(posedge sclk);
        #1;
        out_ready = 1'b1;
        send(vecs[4], 1'b1);
        drain();

        // op_count wrap
        do_reset();
        quiet = 1'b1;
        for (int i = 0; i < 65535; i++) send(v_inc, 1'b0);
        drain();
        @(negedge sclk);
        check("count_ffff", {16'd0, op_count0}, 32'h0000FFFF);
        @(posedge sclk);
        #1;
        send(v_inc, 1'b0);
        drain();
        @(negedge sclk);
        check("count_wrap", {16'd0, op_count0}, 32'd0);
        quiet = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
